seq_mult_unit: RTL and testbench

//   Multi-cycle shift-add multiplier for MULT/MULTU in the EX stage, directly

---
 rtl/seq_mult_unit_if.sv | 36 +++
 rtl/seq_mult_unit.sv | 123 ++++++++++++
 tb/tb_seq_mult_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_mult_unit_if.sv
// Handshake and data bundle between the EX-stage control and the sequential
// multiplier.
//   master : drives Start/Signed_Op/Abort/Op_A/Op_B, observes status and product
//   slave  : the multiplier itself
// Signals:
//   Start      launch request (sampled only when the unit is idle)
//   Signed_Op  1 = MULT (two's complement), 0 = MULTU
//   Abort      pipeline flush, cancels an in-flight operation
//   Op_A/Op_B  multiplicand (rs) / multiplier (rt)
//   Busy       unit is not idle
//   Done       one-cycle completion pulse (HI/LO write enable, stall release)
//   Hi_Out     product upper half, held between operations
//   Lo_Out     product lower half, held between operations
interface seq_mult_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Start;
  logic             Signed_Op;
  logic             Abort;
  logic [WIDTH-1:0] Op_A;
  logic [WIDTH-1:0] Op_B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi_Out;
  logic [WIDTH-1:0] Lo_Out;

  modport master (
    output Start, Signed_Op, Abort, Op_A, Op_B,
    input  Busy, Done, Hi_Out, Lo_Out
  );

  modport slave (
    input  Start, Signed_Op, Abort, Op_A, Op_B,
    output Busy, Done, Hi_Out, Lo_Out
  );
endinterface

// File: rtl/seq_mult_unit.sv
// Multi-cycle shift-add multiplier for MULT/MULTU, feeding the HI/LO registers.
// One operation takes WIDTH+2 clock edges from the Start edge; the product is
// presented on Hi_Out/Lo_Out together with a one-cycle Done pulse.
// Ports:
//   Clk  rising-edge clock
//   Rst  asynchronous active-high reset
//   bus  seq_mult_unit_if slave modport (Start, Signed_Op, Abort, Op_A, Op_B in;
//        Busy, Done, Hi_Out, Lo_Out out)
module seq_mult_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic           Clk,
  input  logic           Rst,
  seq_mult_unit_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH:0]     acc_hi;
  logic               neg;
  logic [CW-1:0]      count;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // State register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; Abort only matters while an operation is in flight
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (bus.Start) state_next = RUN;
      RUN: begin
        if (bus.Abort)            state_next = IDLE;
        else if (count == CW'(1)) state_next = FIX;
      end
      FIX:  state_next = bus.Abort ? IDLE : DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs
  always_comb begin
    bus.Busy = (state != IDLE);
    bus.Done = (state == DONE);
  end

  // Operand magnitudes; negating the most negative value wraps to itself,
  // which is the correct unsigned magnitude.
  always_comb begin
    a_mag = (bus.Signed_Op && bus.Op_A[WIDTH-1]) ? -bus.Op_A : bus.Op_A;
    b_mag = (bus.Signed_Op && bus.Op_B[WIDTH-1]) ? -bus.Op_B : bus.Op_B;
  end

  // Partial sum keeps the carry in acc_hi's extra bit
  always_comb begin
    sum     = acc_hi + (mplier[0] ? {1'b0, mcand} : '0);
    product = {acc_hi[WIDTH-1:0], mplier};
    result  = neg ? -product : product;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mcand      <= '0;
      mplier     <= '0;
      acc_hi     <= '0;
      neg        <= 1'b0;
      count      <= '0;
      bus.Hi_Out <= '0;
      bus.Lo_Out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.Start) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            acc_hi <= '0;
            neg    <= bus.Signed_Op & (bus.Op_A[WIDTH-1] ^ bus.Op_B[WIDTH-1]);
            count  <= CW'(WIDTH);
          end
        end
        RUN: begin
          // {sum, mplier} >> 1: consumed multiplier bits make room for the
          // low product bits shifting in from the accumulator.
          acc_hi <= {1'b0, sum[WIDTH:1]};
          mplier <= {sum[0], mplier[WIDTH-1:1]};
          count  <= count - CW'(1);
        end
        FIX: begin
          if (!bus.Abort) begin
            bus.Hi_Out <= result[2*WIDTH-1:WIDTH];
            bus.Lo_Out <= result[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_unit.sv
module tb_seq_mult_unit;

  logic Clk = 1'b0;
  logic Rst;
  int   total  = 0;
  int   passed = 0;

  always #5 Clk = ~Clk;

  seq_mult_unit_if #(.WIDTH(32)) bus ();

  seq_mult_unit #(.WIDTH(32)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  // Reference: full-precision product from plain integer arithmetic
  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  // Drive one Start cycle; returns at the falling edge after the Start edge
  task automatic launch(input bit s, input logic [31:0] a, input logic [31:0] b, input bit ab);
    @(negedge Clk);
    bus.Start = 1'b1; bus.Signed_Op = s; bus.Op_A = a; bus.Op_B = b; bus.Abort = ab;
    @(negedge Clk);
    bus.Start = 1'b0; bus.Abort = 1'b0;
    bus.Op_A = $urandom; bus.Op_B = $urandom; bus.Signed_Op = 1'($urandom_range(0, 1));
  endtask

  // Bounded wait for Done, counting falling edges
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.Done !== 1'b1 && cyc < 100) begin
      @(negedge Clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    total++; if (bus.Busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.Busy); else passed++;
    total++; if (bus.Done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.Done); else passed++;
    total++; if (bus.Hi_Out !== 32'h0) $display("FAIL reset_hi: got %h expected 0", bus.Hi_Out); else passed++;
    total++; if (bus.Lo_Out !== 32'h0) $display("FAIL reset_lo: got %h expected 0", bus.Lo_Out); else passed++;
    Rst = 1'b0;
  endtask

  task automatic test_max_unsigned;
    int cyc;
    launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    total++; if (bus.Busy !== 1'b1) $display("FAIL max_busy_run: got %b expected 1", bus.Busy); else passed++;
    wait_done(cyc);
    total++; if (cyc != 33) $display("FAIL max_latency: got %0d expected 33", cyc); else passed++;
    total++; if (bus.Hi_Out !== 32'hFFFF_FFFE) $display("FAIL max_hi: got %h expected fffffffe", bus.Hi_Out); else passed++;
    total++; if (bus.Lo_Out !== 32'h0000_0001) $display("FAIL max_lo: got %h expected 00000001", bus.Lo_Out); else passed++;
    total++; if (bus.Busy !== 1'b1) $display("FAIL max_busy_done: got %b expected 1", bus.Busy); else passed++;
    @(negedge Clk);
    total++; if (bus.Done !== 1'b0) $display("FAIL max_done_width: got %b expected 0", bus.Done); else passed++;
    total++; if (bus.Busy !== 1'b0) $display("FAIL max_busy_idle: got %b expected 0", bus.Busy); else passed++;
  endtask

  task automatic test_corner_values;
    bit          s [6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] a [6]  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h7, 32'h0, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] b [6]  = '{32'h5, 32'h8000_0000, 32'h0, 32'h1234_5678, 32'h1, 32'h8000_0000};
    logic [31:0] eh [6] = '{32'hFFFF_FFFF, 32'h4000_0000, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h4000_0000};
    logic [31:0] el [6] = '{32'hFFFF_FFF1, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0};
    int cyc;
    for (int i = 0; i < 6; i++) begin
      launch(s[i], a[i], b[i], 1'b0);
      wait_done(cyc);
      total++; if (cyc != 33) $display("FAIL corner%0d_latency: got %0d expected 33", i, cyc); else passed++;
      total++; if (bus.Hi_Out !== eh[i]) $display("FAIL corner%0d_hi: got %h expected %h", i, bus.Hi_Out, eh[i]); else passed++;
      total++; if (bus.Lo_Out !== el[i]) $display("FAIL corner%0d_lo: got %h expected %h", i, bus.Lo_Out, el[i]); else passed++;
    end
  endtask

  task automatic test_random_ops;
    logic [31:0] a, b;
    logic [63:0] exp;
    bit          s;
    int          cyc;
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      if (i % 6 == 1) a = 32'h8000_0000;
      if (i % 6 == 4) b = 32'hFFFF_FFFF;
      exp = model(s, a, b);
      launch(s, a, b, 1'b0);
      wait_done(cyc);
      total++; if (cyc != 33) $display("FAIL rand%0d_latency: got %0d expected 33", i, cyc); else passed++;
      total++; if ({bus.Hi_Out, bus.Lo_Out} !== exp) $display("FAIL rand%0d_product: s=%0d a=%h b=%h got %h_%h expected %h", i, s, a, b, bus.Hi_Out, bus.Lo_Out, exp); else passed++;
    end
  endtask

  task automatic test_start_while_busy;
    logic [63:0] exp;
    int          cyc, extra;
    exp = model(1'b1, 32'h0001_2345, 32'hFFFF_FF00);
    launch(1'b1, 32'h0001_2345, 32'hFFFF_FF00, 1'b0);
    repeat (4) @(negedge Clk);
    bus.Start = 1'b1; bus.Signed_Op = 1'b0; bus.Op_A = 32'hDEAD_BEEF; bus.Op_B = 32'h0BAD_F00D;
    @(negedge Clk);
    bus.Start = 1'b0;
    wait_done(cyc);
    total++; if (cyc != 28) $display("FAIL busy_start_latency: got %0d expected 28", cyc); else passed++;
    total++; if ({bus.Hi_Out, bus.Lo_Out} !== exp) $display("FAIL busy_start_product: got %h_%h expected %h", bus.Hi_Out, bus.Lo_Out, exp); else passed++;
    extra = 0;
    repeat (40) begin
      @(negedge Clk);
      if (bus.Done === 1'b1) extra++;
    end
    total++; if (extra != 0) $display("FAIL busy_start_extra_done: got %0d expected 0", extra); else passed++;
  endtask

  task automatic test_abort;
    logic [63:0] prev, exp;
    int          cyc, dones;
    prev = model(1'b0, 32'h0000_0010, 32'hA000_0000);
    launch(1'b0, 32'h0000_0010, 32'hA000_0000, 1'b0);
    wait_done(cyc);
    total++; if ({bus.Hi_Out, bus.Lo_Out} !== prev) $display("FAIL abort_prior: got %h_%h expected %h", bus.Hi_Out, bus.Lo_Out, prev); else passed++;
    // Abort in RUN cycle 10
    launch(1'b1, 32'h1357_9BDF, 32'h2468_ACE0, 1'b0);
    repeat (9) @(negedge Clk);
    bus.Abort = 1'b1;
    @(negedge Clk);
    bus.Abort = 1'b0;
    total++; if (bus.Busy !== 1'b0) $display("FAIL abort_run_busy: got %b expected 0", bus.Busy); else passed++;
    dones = 0;
    repeat (40) begin
      @(negedge Clk);
      if (bus.Done === 1'b1) dones++;
    end
    total++; if (dones != 0) $display("FAIL abort_run_done: got %0d expected 0", dones); else passed++;
    total++; if ({bus.Hi_Out, bus.Lo_Out} !== prev) $display("FAIL abort_run_hold: got %h_%h expected %h", bus.Hi_Out, bus.Lo_Out, prev); else passed++;
    // Abort during the FIX cycle: result must not be written
    launch(1'b0, 32'h0000_0003, 32'h0000_0003, 1'b0);
    repeat (32) @(negedge Clk);
    total++; if (bus.Busy !== 1'b1) $display("FAIL abort_fix_busy_before: got %b expected 1", bus.Busy); else passed++;
    bus.Abort = 1'b1;
    @(negedge Clk);
    bus.Abort = 1'b0;
    total++; if (bus.Busy !== 1'b0) $display("FAIL abort_fix_busy: got %b expected 0", bus.Busy); else passed++;
    total++; if (bus.Done !== 1'b0) $display("FAIL abort_fix_done: got %b expected 0", bus.Done); else passed++;
    total++; if ({bus.Hi_Out, bus.Lo_Out} !== prev) $display("FAIL abort_fix_hold: got %h_%h expected %h", bus.Hi_Out, bus.Lo_Out, prev); else passed++;
    // Start together with Abort in IDLE still launches
    exp = model(1'b1, 32'hFFFF_FFF9, 32'h0000_0006);
    launch(1'b1, 32'hFFFF_FFF9, 32'h0000_0006, 1'b1);
    wait_done(cyc);
    total++; if (cyc != 33) $display("FAIL abort_idle_latency: got %0d expected 33", cyc); else passed++;
    total++; if ({bus.Hi_Out, bus.Lo_Out} !== exp) $display("FAIL abort_idle_product: got %h_%h expected %h", bus.Hi_Out, bus.Lo_Out, exp); else passed++;
  endtask

  task automatic test_async_reset;
    logic [63:0] exp;
    int          cyc;
    launch(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (7) @(negedge Clk);
    #2 Rst = 1'b1;
    #1;
    total++; if (bus.Busy !== 1'b0) $display("FAIL arst_busy: got %b expected 0", bus.Busy); else passed++;
    total++; if (bus.Done !== 1'b0) $display("FAIL arst_done: got %b expected 0", bus.Done); else passed++;
    total++; if (bus.Hi_Out !== 32'h0) $display("FAIL arst_hi: got %h expected 0", bus.Hi_Out); else passed++;
    total++; if (bus.Lo_Out !== 32'h0) $display("FAIL arst_lo: got %h expected 0", bus.Lo_Out); else passed++;
    @(negedge Clk);
    Rst = 1'b0;
    exp = model(1'b1, 32'h8000_0001, 32'h7FFF_FFFF);
    launch(1'b1, 32'h8000_0001, 32'h7FFF_FFFF, 1'b0);
    wait_done(cyc);
    total++; if (cyc != 33) $display("FAIL arst_next_latency: got %0d expected 33", cyc); else passed++;
    total++; if ({bus.Hi_Out, bus.Lo_Out} !== exp) $display("FAIL arst_next_product: got %h_%h expected %h", bus.Hi_Out, bus.Lo_Out, exp); else passed++;
  endtask

  initial begin
    Rst = 1'b1;
    bus.Start = 1'b0; bus.Signed_Op = 1'b0; bus.Abort = 1'b0;
    bus.Op_A = '0; bus.Op_B = '0;
    test_reset();
    test_max_unsigned();
    test_corner_values();
    test_random_ops();
    test_start_while_busy();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d so far", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule
